alu_issue_sequencer: RTL

- Issue and sequence controller for the 16-bit execution datapath. Accepts one decoded operation at a time (opcode, rs1/rs2 values, destination register). Sequences it through single-cycle or multi-cycle execution, then holds the result until the writeback stage takes it.
- Provides the valid/ready framing and multi-cycle timing that a purely combinational opcode-routed operand path lacks.

---
 rtl/alu_issue_sequencer_if.sv | 39 +++
 rtl/alu_issue_sequencer.sv | 167 ++++++++++++++++
 2 files changed

// File: rtl/alu_issue_sequencer_if.sv
// Issue / result bundle between the decode stage, the ALU issue sequencer
// and the writeback stage.
//   master : issuing side (drives the operation, consumes the result)
//   slave  : the sequencer (accepts the operation, presents the result)
// Signals:
//   in_valid / in_ready        issue handshake
//   op_opcode, rs1_reg_val,
//   rs2_reg_val, rd_addr       decoded operation, sampled at the issue edge
//   out_valid / out_ready      result handshake
//   result, out_rd, illegal_op result payload, stable while out_valid
//   busy                       sequencer is not idle
interface alu_issue_sequencer_if #(
    parameter int N    = 16,
    parameter int SEL  = 4,
    parameter int RD_W = 4
);
    logic            in_valid;
    logic            in_ready;
    logic [SEL-1:0]  op_opcode;
    logic [N-1:0]    rs1_reg_val;
    logic [N-1:0]    rs2_reg_val;
    logic [RD_W-1:0] rd_addr;
    logic            out_valid;
    logic            out_ready;
    logic [N-1:0]    result;
    logic [RD_W-1:0] out_rd;
    logic            illegal_op;
    logic            busy;

    modport master (
        output in_valid, op_opcode, rs1_reg_val, rs2_reg_val, rd_addr, out_ready,
        input  in_ready, out_valid, result, out_rd, illegal_op, busy
    );

    modport slave (
        input  in_valid, op_opcode, rs1_reg_val, rs2_reg_val, rd_addr, out_ready,
        output in_ready, out_valid, result, out_rd, illegal_op, busy
    );
endinterface

// File: rtl/alu_issue_sequencer.sv
// ALU issue sequencer: accepts one decoded operation at a time, runs it
// through a single-cycle path (ADD/SUB/AND/OR/XOR/LI/illegal), a delayed
// multiply path (MUL_LAT cycles) or a bit-serial restoring divider
// (N+1 cycles), then holds the result until writeback accepts it.
// Ports:
//   clk    rising-edge clock
//   rst_n  asynchronous active-low reset; abandons any operation in flight
//   io     issue/result bundle (slave side), see alu_issue_sequencer_if
module alu_issue_sequencer #(
    parameter int N       = 16,
    parameter int SEL     = 4,
    parameter int RD_W    = 4,
    parameter int MUL_LAT = 3
) (
    input  logic                  clk,
    input  logic                  rst_n,
    alu_issue_sequencer_if.slave  io
);
    localparam int CNT_MAX = (N > MUL_LAT) ? N : MUL_LAT;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    localparam logic [SEL-1:0] OP_ADD = SEL'(0);
    localparam logic [SEL-1:0] OP_SUB = SEL'(1);
    localparam logic [SEL-1:0] OP_MUL = SEL'(2);
    localparam logic [SEL-1:0] OP_DIV = SEL'(3);
    localparam logic [SEL-1:0] OP_AND = SEL'(4);
    localparam logic [SEL-1:0] OP_OR  = SEL'(5);
    localparam logic [SEL-1:0] OP_XOR = SEL'(6);
    localparam logic [SEL-1:0] OP_LI  = SEL'(7);

    typedef enum logic [1:0] {IDLE, EXEC, DONE} state_t;

    state_t          state_reg, state_next;
    logic            init_done_reg;
    logic [N-1:0]    a_reg, b_reg, rem_reg, quo_reg, result_reg;
    logic [CNT_W-1:0] cnt_reg;
    logic            div_reg, illegal_reg;
    logic [RD_W-1:0] out_rd_reg;

    logic            in_ready_int, out_valid_int, busy_int;
    logic            issue, transfer, exec_last;
    logic            is_mul_in, is_div_in, is_illegal_in, multi_in;
    logic [N-1:0]    single_result, prod_low;
    logic [N:0]      rem_shift;
    logic            rem_ge;
    logic [N-1:0]    rem_next, quo_next;

    // ---------------- decode of the issuing operation ----------------
    assign is_mul_in     = (io.op_opcode == OP_MUL);
    assign is_div_in     = (io.op_opcode == OP_DIV);
    assign is_illegal_in = (io.op_opcode > OP_LI);
    // With MUL_LAT==1 the multiply completes on the single-cycle path.
    assign multi_in      = is_div_in || (is_mul_in && (MUL_LAT > 1));

    assign issue     = io.in_valid && in_ready_int;
    assign transfer  = out_valid_int && io.out_ready;
    assign exec_last = (cnt_reg == CNT_W'(1));

    always_comb begin
        single_result = '0;
        case (io.op_opcode)
            OP_ADD:  single_result = io.rs1_reg_val + io.rs2_reg_val;
            OP_SUB:  single_result = io.rs1_reg_val - io.rs2_reg_val;
            OP_MUL:  single_result = io.rs1_reg_val * io.rs2_reg_val;
            OP_AND:  single_result = io.rs1_reg_val & io.rs2_reg_val;
            OP_OR:   single_result = io.rs1_reg_val | io.rs2_reg_val;
            OP_XOR:  single_result = io.rs1_reg_val ^ io.rs2_reg_val;
            OP_LI:   single_result = io.rs1_reg_val;
            default: single_result = '0;
        endcase
    end

    // ---------------- multi-cycle datapath ----------------
    assign prod_low = a_reg * b_reg;

    // Restoring divide step: the dividend is shifted out of quo_reg into the
    // partial remainder while quotient bits are shifted in. A zero divisor
    // always "fits", which yields an all-ones quotient with no special case.
    assign rem_shift = {rem_reg, quo_reg[N-1]};
    assign rem_ge    = (rem_shift >= {1'b0, b_reg});
    assign rem_next  = rem_ge ? (rem_shift[N-1:0] - b_reg) : rem_shift[N-1:0];
    assign quo_next  = {quo_reg[N-2:0], rem_ge};

    // ---------------- FSM: state register ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg     <= IDLE;
            init_done_reg <= 1'b0;
        end else begin
            state_reg     <= state_next;
            init_done_reg <= 1'b1;
        end
    end

    // ---------------- FSM: next state ----------------
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (issue) state_next = multi_in ? EXEC : DONE;
            EXEC:    if (exec_last) state_next = DONE;
            DONE:    if (transfer) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // ---------------- FSM: outputs ----------------
    always_comb begin
        in_ready_int  = 1'b0;
        out_valid_int = 1'b0;
        busy_int      = 1'b1;
        case (state_reg)
            IDLE: begin
                // Held low until the first edge after reset release.
                in_ready_int = init_done_reg;
                busy_int     = 1'b0;
            end
            EXEC:    ;
            DONE:    out_valid_int = 1'b1;
            default: busy_int = 1'b0;
        endcase
    end

    // ---------------- operand / result registers ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_reg       <= '0;
            b_reg       <= '0;
            rem_reg     <= '0;
            quo_reg     <= '0;
            cnt_reg     <= '0;
            div_reg     <= 1'b0;
            result_reg  <= '0;
            out_rd_reg  <= '0;
            illegal_reg <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: if (issue) begin
                    a_reg       <= io.rs1_reg_val;
                    b_reg       <= io.rs2_reg_val;
                    quo_reg     <= io.rs1_reg_val;
                    rem_reg     <= '0;
                    div_reg     <= is_div_in;
                    out_rd_reg  <= io.rd_addr;
                    illegal_reg <= is_illegal_in;
                    result_reg  <= single_result;
                    cnt_reg     <= is_div_in ? CNT_W'(N) : CNT_W'(MUL_LAT - 1);
                end
                EXEC: begin
                    cnt_reg <= cnt_reg - CNT_W'(1);
                    if (div_reg) begin
                        rem_reg <= rem_next;
                        quo_reg <= quo_next;
                    end
                    if (exec_last) result_reg <= div_reg ? quo_next : prod_low;
                end
                default: ;
            endcase
        end
    end

    assign io.in_ready   = in_ready_int;
    assign io.out_valid  = out_valid_int;
    assign io.busy       = busy_int;
    assign io.result     = result_reg;
    assign io.out_rd     = out_rd_reg;
    assign io.illegal_op = illegal_reg;
endmodule
